// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: inhibit, start bit, 8 data + odd parity + stop, device ACK check.
// Optional build macro PS2_TX_RETRY_EN: retry a failed transfer up to twice before reporting.
module ps2_host_tx #(
    parameter int CLKMHZ           = 14,
    parameter int INHIBIT_US       = 120,
    parameter int START_TIMEOUT_US = 15000,
    parameter int FRAME_TIMEOUT_US = 2000,
    parameter int FILTER_LEN       = 8
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [7:0] data_in,
    input  logic       send,
    output logic       busy,
    output logic       done,
    output logic [1:0] status,
    output logic       rx_enable,
    input  logic       ps2clk_ext,
    input  logic       ps2data_ext,
    output logic       ps2clk_oe,
    output logic       ps2data_oe
);
    localparam int INHIBIT_CYC = INHIBIT_US * CLKMHZ;
    localparam int START_CYC   = START_TIMEOUT_US * CLKMHZ;
    localparam int FRAME_CYC   = FRAME_TIMEOUT_US * CLKMHZ;
    localparam int MAX_SF      = (START_CYC > FRAME_CYC) ? START_CYC : FRAME_CYC;
    localparam int MAX_CYC     = (MAX_SF > INHIBIT_CYC) ? MAX_SF : INHIBIT_CYC;
    localparam int TMR_W       = $clog2(MAX_CYC);
    localparam int FILT_W      = $clog2(FILTER_LEN + 1);

    typedef enum logic [2:0] {
        ST_IDLE, ST_INHIBIT, ST_RELEASE, ST_SHIFT, ST_WAIT_IDLE, ST_END_ATTEMPT, ST_FINISH
    } state_t;

    logic [1:0]        clk_sync_reg, data_sync_reg;
    logic [FILT_W-1:0] filt_cnt_reg;
    logic              filt_clk_reg;
    logic              fe_reg;

    state_t            state_reg;
    logic              busy_reg, done_reg, clk_oe_reg, data_oe_reg;
    logic [1:0]        status_reg, result_reg;
    logic [7:0]        data_reg;
    logic              parity_reg;
    logic [TMR_W-1:0]  tmr_reg;
    logic [3:0]        bit_cnt_reg;
    logic [9:0]        frame;
`ifdef PS2_TX_RETRY_EN
    logic [1:0]        retry_reg;
`endif

    // Bits shifted out after the start bit: data LSB first, parity, stop
    assign frame = {1'b1, parity_reg, data_reg};

    // Pin synchronizers plus clock deglitch; fe pulses when the filtered clock falls
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            clk_sync_reg  <= 2'b11;
            data_sync_reg <= 2'b11;
            filt_cnt_reg  <= '0;
            filt_clk_reg  <= 1'b1;
            fe_reg        <= 1'b0;
        end else begin
            clk_sync_reg  <= {clk_sync_reg[0], ps2clk_ext};
            data_sync_reg <= {data_sync_reg[0], ps2data_ext};
            fe_reg        <= 1'b0;
            if (clk_sync_reg[1] == filt_clk_reg) begin
                filt_cnt_reg <= '0;
            end else if (filt_cnt_reg == FILT_W'(FILTER_LEN - 1)) begin
                filt_clk_reg <= clk_sync_reg[1];
                filt_cnt_reg <= '0;
                fe_reg       <= filt_clk_reg;
            end else begin
                filt_cnt_reg <= filt_cnt_reg + FILT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg   <= ST_IDLE;
            busy_reg    <= 1'b0;
            done_reg    <= 1'b0;
            status_reg  <= 2'b00;
            result_reg  <= 2'b00;
            clk_oe_reg  <= 1'b0;
            data_oe_reg <= 1'b0;
            data_reg    <= '0;
            parity_reg  <= 1'b0;
            tmr_reg     <= '0;
            bit_cnt_reg <= '0;
`ifdef PS2_TX_RETRY_EN
            retry_reg   <= '0;
`endif
        end else begin
            done_reg <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    if (send) begin
                        data_reg   <= data_in;
                        parity_reg <= ~^data_in;
                        busy_reg   <= 1'b1;
                        clk_oe_reg <= 1'b1;
                        tmr_reg    <= '0;
`ifdef PS2_TX_RETRY_EN
                        retry_reg  <= '0;
`endif
                        state_reg  <= ST_INHIBIT;
                    end
                end
                ST_INHIBIT: begin
                    if (tmr_reg == TMR_W'(INHIBIT_CYC - 1)) begin
                        clk_oe_reg <= 1'b0;
                        tmr_reg    <= '0;
                        state_reg  <= ST_RELEASE;
                    end else begin
                        tmr_reg <= tmr_reg + TMR_W'(1);
                        // Start bit overlaps the final inhibit cycle
                        if (tmr_reg == TMR_W'(INHIBIT_CYC - 2))
                            data_oe_reg <= 1'b1;
                    end
                end
                ST_RELEASE: begin
                    if (fe_reg) begin
                        data_oe_reg <= ~frame[0];
                        bit_cnt_reg <= 4'd1;
                        tmr_reg     <= '0;
                        state_reg   <= ST_SHIFT;
                    end else if (tmr_reg == TMR_W'(START_CYC - 1)) begin
                        data_oe_reg <= 1'b0;
                        result_reg  <= 2'b10;
                        state_reg   <= ST_END_ATTEMPT;
                    end else begin
                        tmr_reg <= tmr_reg + TMR_W'(1);
                    end
                end
                ST_SHIFT: begin
                    if (tmr_reg == TMR_W'(FRAME_CYC - 1)) begin
                        data_oe_reg <= 1'b0;
                        result_reg  <= 2'b10;
                        state_reg   <= ST_END_ATTEMPT;
                    end else begin
                        tmr_reg <= tmr_reg + TMR_W'(1);
                        if (fe_reg) begin
                            if (bit_cnt_reg == 4'd10) begin
                                result_reg <= {1'b0, data_sync_reg[1]};
                                state_reg  <= ST_WAIT_IDLE;
                            end else begin
                                data_oe_reg <= ~frame[bit_cnt_reg];
                                bit_cnt_reg <= bit_cnt_reg + 4'd1;
                            end
                        end
                    end
                end
                ST_WAIT_IDLE: begin
                    if (filt_clk_reg && data_sync_reg[1]) begin
                        state_reg <= ST_END_ATTEMPT;
                    end else if (tmr_reg == TMR_W'(FRAME_CYC - 1)) begin
                        data_oe_reg <= 1'b0;
                        result_reg  <= 2'b10;
                        state_reg   <= ST_END_ATTEMPT;
                    end else begin
                        tmr_reg <= tmr_reg + TMR_W'(1);
                    end
                end
                ST_END_ATTEMPT: begin
`ifdef PS2_TX_RETRY_EN
                    if (result_reg != 2'b00 && retry_reg != 2'd2) begin
                        retry_reg  <= retry_reg + 2'd1;
                        clk_oe_reg <= 1'b1;
                        tmr_reg    <= '0;
                        state_reg  <= ST_INHIBIT;
                    end else
`endif
                    begin
                        done_reg   <= 1'b1;
                        status_reg <= result_reg;
                        state_reg  <= ST_FINISH;
                    end
                end
                ST_FINISH: begin
                    busy_reg  <= 1'b0;
                    state_reg <= ST_IDLE;
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

    assign busy       = busy_reg;
    assign done       = done_reg;
    assign status     = status_reg;
    assign rx_enable  = ~busy_reg;
    assign ps2clk_oe  = clk_oe_reg;
    assign ps2data_oe = data_oe_reg;
endmodule

// File: tb/tb_ps2_host_tx.sv
// Directed bench for ps2_host_tx with an open-drain PS/2 device model.
module tb_ps2_host_tx;
    localparam int HALF      = 20;
    localparam int START_US  = 300;
    localparam int INH_CYC   = 120 * 14;
    localparam int START_CYC = START_US * 14;
`ifdef PS2_TX_RETRY_EN
    localparam int ATTEMPTS = 3;
`else
    localparam int ATTEMPTS = 1;
`endif

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic [7:0] data_in = 8'h00;
    logic       send = 1'b0;
    logic       busy, done, rx_enable, ps2clk_oe, ps2data_oe;
    logic [1:0] status;
    logic       dev_clk_low = 1'b0, dev_data_low = 1'b0;
    wire        ps2clk_line  = ~(ps2clk_oe | dev_clk_low);
    wire        ps2data_line = ~(ps2data_oe | dev_data_low);

    int total = 0, bad = 0;
    int cyc = 0, done_cnt = 0, done_cyc = 0, inhibit_cnt = 0, oe_cycles = 0, rx_bad = 0;
    logic [1:0] done_status = 2'b00;
    logic done_clk_oe = 1'b0, done_data_oe = 1'b0, clk_oe_prev = 1'b0;

    ps2_host_tx #(
        .CLKMHZ(14), .INHIBIT_US(120), .START_TIMEOUT_US(START_US),
        .FRAME_TIMEOUT_US(2000), .FILTER_LEN(8)
    ) dut (
        .clk(clk), .reset_n(reset_n), .data_in(data_in), .send(send),
        .busy(busy), .done(done), .status(status), .rx_enable(rx_enable),
        .ps2clk_ext(ps2clk_line), .ps2data_ext(ps2data_line),
        .ps2clk_oe(ps2clk_oe), .ps2data_oe(ps2data_oe)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        #1;
        cyc++;
        if (done) begin
            done_cnt++;
            done_cyc     = cyc;
            done_status  = status;
            done_clk_oe  = ps2clk_oe;
            done_data_oe = ps2data_oe;
        end
        if (ps2clk_oe && !clk_oe_prev) inhibit_cnt++;
        clk_oe_prev = ps2clk_oe;
        if (ps2clk_oe) oe_cycles++;
        if (rx_enable !== ~busy) rx_bad++;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic do_send(input logic [7:0] b, output int send_cyc);
        @(negedge clk);
        data_in = b;
        send = 1'b1;
        @(negedge clk);
        send = 1'b0;
        data_in = ~b;
        send_cyc = cyc;
    endtask

    task automatic wait_done(input int base, input int bound);
        int t = 0;
        while (done_cnt == base && t < bound) begin
            @(negedge clk);
            t++;
        end
        chk("done_seen", done_cnt - base, 1);
    endtask

    // Device side: clocks 11 falling edges, captures bits 1..10 before each rising edge
    task automatic device_frame(input bit ack, input bit glitch, input bit resend,
                                input bit abort, output logic [9:0] bits);
        int t;
        bits = '0;
        t = 0;
        while (!ps2clk_oe && t < 200) begin @(negedge clk); t++; end
        t = 0;
        while (ps2clk_oe && t < 5000) begin @(negedge clk); t++; end
        repeat (40) @(negedge clk);
        for (int k = 1; k <= 11; k++) begin
            if (k == 11) dev_data_low = ack;
            dev_clk_low = 1'b1;
            if (abort && k == 5) begin
                repeat (12) @(negedge clk);
                #2 reset_n = 1'b0;
                #1;
                chk("rst_clk_oe", ps2clk_oe, 0);
                chk("rst_data_oe", ps2data_oe, 0);
                chk("rst_busy", busy, 0);
                dev_clk_low = 1'b0;
                dev_data_low = 1'b0;
                repeat (3) @(negedge clk);
                reset_n = 1'b1;
                return;
            end
            repeat (HALF) @(negedge clk);
            if (k <= 10) bits[k-1] = ps2data_line;
            dev_clk_low = 1'b0;
            if (glitch && k == 3) begin
                repeat (6) @(negedge clk);
                dev_clk_low = 1'b1;
                repeat (3) @(negedge clk);
                dev_clk_low = 1'b0;
                repeat (HALF - 9) @(negedge clk);
            end else if (resend && k == 6) begin
                send = 1'b1;
                data_in = 8'hFF;
                @(negedge clk);
                send = 1'b0;
                repeat (HALF - 1) @(negedge clk);
            end else begin
                repeat (HALF) @(negedge clk);
            end
        end
        dev_data_low = 1'b0;
    endtask

    logic [7:0] vec_data [5] = '{8'hED, 8'h00, 8'h01, 8'hA5, 8'h3C};
    logic       vec_par  [5] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1};

    task automatic good_transfer(input int idx, input bit glitch, input bit resend);
        logic [9:0] bits;
        int dbase, ibase, obase, sc;
        dbase = done_cnt; ibase = inhibit_cnt; obase = oe_cycles;
        do_send(vec_data[idx], sc);
        device_frame(1'b1, glitch, resend, 1'b0, bits);
        wait_done(dbase, 500);
        chk("data_bits", bits[7:0], vec_data[idx]);
        chk("parity_bit", bits[8], vec_par[idx]);
        chk("stop_bit", bits[9], 1);
        chk("status_ack", done_status, 2'b00);
        chk("inhibit_len", oe_cycles - obase, INH_CYC);
        repeat (3) @(negedge clk);
        chk("busy_after", busy, 0);
        if (resend) begin
            repeat (2500) @(negedge clk);
            chk("resend_done_cnt", done_cnt - dbase, 1);
            chk("resend_inhibits", inhibit_cnt - ibase, 1);
        end
    endtask

    initial begin
        logic [9:0] bits;
        int dbase, ibase, sc, lat;

        repeat (3) @(negedge clk);
        chk("reset_busy", busy, 0);
        chk("reset_done", done, 0);
        chk("reset_status", status, 2'b00);
        chk("reset_clk_oe", ps2clk_oe, 0);
        chk("reset_data_oe", ps2data_oe, 0);
        chk("reset_rx_enable", rx_enable, 1);
        reset_n = 1'b1;
        repeat (5) @(negedge clk);

        for (int i = 0; i < 3; i++) good_transfer(i, 1'b0, 1'b0);

        // device leaves data high on the ACK clock
        dbase = done_cnt; ibase = inhibit_cnt;
        do_send(8'hF4, sc);
        for (int a = 0; a < ATTEMPTS; a++) device_frame(1'b0, 1'b0, 1'b0, 1'b0, bits);
        wait_done(dbase, 500);
        chk("nack_status", done_status, 2'b01);
        chk("nack_inhibits", inhibit_cnt - ibase, ATTEMPTS);
        repeat (50) @(negedge clk);
        chk("nack_done_cnt", done_cnt - dbase, 1);

        // device never clocks
        dbase = done_cnt; ibase = inhibit_cnt;
        do_send(8'h55, sc);
        wait_done(dbase, ATTEMPTS * (INH_CYC + START_CYC + 10));
        chk("timeout_status", done_status, 2'b10);
        chk("timeout_clk_oe", done_clk_oe, 0);
        chk("timeout_data_oe", done_data_oe, 0);
        chk("timeout_inhibits", inhibit_cnt - ibase, ATTEMPTS);
        if (ATTEMPTS == 1) begin
            lat = done_cyc - sc;
            chk("timeout_latency_in_window",
                (lat >= INH_CYC + START_CYC - 2 && lat <= INH_CYC + START_CYC + 2), 1);
        end
        repeat (5) @(negedge clk);
        chk("timeout_data_oe_after", ps2data_oe, 0);

        // reset around the fifth falling edge
        dbase = done_cnt;
        do_send(8'h00, sc);
        device_frame(1'b1, 1'b0, 1'b0, 1'b1, bits);
        repeat (50) @(negedge clk);
        chk("rst_no_done", done_cnt - dbase, 0);
        chk("rst_busy_after", busy, 0);
        chk("rst_status_cleared", status, 2'b00);

        good_transfer(3, 1'b0, 1'b0);
        good_transfer(4, 1'b1, 1'b1);

        chk("rx_enable_tracks_busy", rx_bad, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
